// File: rtl/conv3x3_stream_if.sv
// Pixel-in / result-out bundle for conv3x3_stream.
// The master side is the pixel source and result sink; the slave side is the engine.
interface conv3x3_stream_if #(
    parameter int DW = 8,
    parameter int OW = 13
) ();
    logic          start;
    logic [1:0]    m;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pix;
    logic          out_valid;
    logic [OW-1:0] out_pix;
    logic          busy;
    logic          ans;

    modport master (
        output start, m, in_valid, in_pix,
        input  in_ready, out_valid, out_pix, busy, ans
    );

    modport slave (
        input  start, m, in_valid, in_pix,
        output in_ready, out_valid, out_pix, busy, ans
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over one raster-order frame, with four fixed kernels.
// Two line buffers feed a 3x3 window; saturated results are registered one cycle after the pixel that completes a window.
module conv3x3_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int OW    = 13
) (
    input  logic              clk,
    input  logic              rst,
    conv3x3_stream_if.slave   bus
);
    localparam int AW       = DW + 5;
    localparam int CW       = ((AW > OW) ? AW : OW) + 1;
    localparam int XW       = $clog2(IMG_W);
    localparam int YW       = $clog2(IMG_H);
    localparam int LB_DEPTH = 1 << XW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      mode_reg;
    logic [XW-1:0]   col_reg, col_next;
    logic [YW-1:0]   row_reg, row_next;
    logic            start_fire, accept, col_last, row_last, win_fire, frame_last;

    logic [DW-1:0]   lb0_mem [LB_DEPTH];
    logic [DW-1:0]   lb1_mem [LB_DEPTH];
    logic [DW-1:0]   lb0_rd, lb1_rd;

    logic [DW-1:0]   new_col [3];
    logic [DW-1:0]   win [3][3];
    logic signed [AW-1:0] prod [9];
    logic signed [AW-1:0] sum_full;
    logic signed [CW-1:0] sum_ext, sat_max, sat_min;
    logic [OW-1:0]   sat_pix;

    logic            out_valid_reg;
    logic [OW-1:0]   out_pix_reg;

    assign start_fire = (state_reg == IDLE) && bus.start;
    assign accept     = (state_reg == RUN) && bus.in_valid;
    assign col_last   = (col_reg == XW'(IMG_W - 1));
    assign row_last   = (row_reg == YW'(IMG_H - 1));
    assign win_fire   = accept && (row_reg >= YW'(2)) && (col_reg >= XW'(2));
    assign frame_last = accept && col_last && row_last;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (frame_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // col_next also addresses the line buffers, so the registered read lands on the column of the next pixel.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (start_fire) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + YW'(1);
            end else begin
                col_next = col_reg + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 2'b00;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            if (start_fire) mode_reg <= bus.m;
        end
    end

    // lb0 holds row r-1 and lb1 holds row r-2; on accept the older row shifts down.
    always_ff @(posedge clk) begin
        lb0_rd <= lb0_mem[col_next];
        lb1_rd <= lb1_mem[col_next];
        if (accept) begin
            lb0_mem[col_reg] <= bus.in_pix;
            lb1_mem[col_reg] <= lb0_rd;
        end
    end

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = bus.in_pix;

    // Only the two older columns are stored; the newest column is taken straight from the incoming pixel.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DW-1:0] tap0_reg, tap1_reg;
            always_ff @(posedge clk) begin
                if (accept) begin
                    tap0_reg <= tap1_reg;
                    tap1_reg <= new_col[gi];
                end
            end
            assign win[gi][0] = tap0_reg;
            assign win[gi][1] = tap1_reg;
            assign win[gi][2] = new_col[gi];
        end
    endgenerate

    function automatic logic signed [3:0] coef(input logic [1:0] mode, input int i, input int j);
        logic signed [3:0] k;
        k = 4'sd0;
        case (mode)
            2'b00: k = (i == 1 && j == 1) ? 4'sd1 : 4'sd0;
            2'b01: k = 4'sd1;
            2'b10: begin
                if (i == 1 && j == 1)            k = 4'sd4;
                else if ((i == 1) != (j == 1))   k = -4'sd1;
                else                             k = 4'sd0;
            end
            default: begin
                if (j == 1)      k = 4'sd0;
                else if (i == 1) k = (j == 0) ? -4'sd2 : 4'sd2;
                else             k = (j == 0) ? -4'sd1 : 4'sd1;
            end
        endcase
        return k;
    endfunction

    generate
        for (gi = 0; gi < 3; gi++) begin : g_prod_row
            for (gj = 0; gj < 3; gj++) begin : g_prod_col
                assign prod[gi*3 + gj] = AW'(coef(mode_reg, gi, gj))
                                       * $signed({{(AW-DW){1'b0}}, win[gi][gj]});
            end
        end
    endgenerate

    always_comb begin
        sum_full = '0;
        for (int k = 0; k < 9; k++) begin
            sum_full = sum_full + prod[k];
        end
    end

    // Clamp bounds are built one bit wider than both AW and OW so either may be the larger.
    assign sum_ext = CW'(sum_full);
    assign sat_max = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    assign sat_min = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        sat_pix = sum_ext[OW-1:0];
        if (sum_ext > sat_max)      sat_pix = sat_max[OW-1:0];
        else if (sum_ext < sat_min) sat_pix = sat_min[OW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_pix_reg   <= '0;
        end else begin
            out_valid_reg <= win_fire;
            if (win_fire) out_pix_reg <= sat_pix;
        end
    end

    assign bus.in_ready  = (state_reg == RUN);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.ans       = (state_reg == DONE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_pix   = out_pix_reg;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on 8x8 frames; a second instance with OW=10 checks saturation.
// Expected results are hand-derived from each frame's pixel pattern.
module tb_conv3x3_stream;
    logic clk = 1'b0;
    logic rst;

    conv3x3_stream_if #(.DW(8), .OW(13)) bus ();
    conv3x3_stream_if #(.DW(8), .OW(10)) bus10 ();

    assign bus10.start    = bus.start;
    assign bus10.m        = bus.m;
    assign bus10.in_valid = bus.in_valid;
    assign bus10.in_pix   = bus.in_pix;

    conv3x3_stream #(.DW(8), .IMG_W(8), .IMG_H(8), .OW(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv3x3_stream #(.DW(8), .IMG_W(8), .IMG_H(8), .OW(10)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q13[$];
    int q10[$];
    int ans_cnt = 0;

    always @(negedge clk) begin
        if (bus.out_valid)   q13.push_back(int'($signed(bus.out_pix)));
        if (bus10.out_valid) q10.push_back(int'($signed(bus10.out_pix)));
        if (bus.ans)         ans_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixv(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'(8*r + c);
            1:       return 8'd255;
            2:       return (r == 3 && c == 3) ? 8'd200 : 8'd0;
            default: return 8'd1;
        endcase
    endfunction

    // Sends one frame; returns right after the last accepting edge (+1), i.e. inside the DONE cycle.
    task automatic send_frame(input int kind, input logic [1:0] mode, input int gaps,
                              input int stop_after, input bit swap_m);
        int n;
        bus.start = 1'b1;
        bus.m     = mode;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("in_ready_run", bus.in_ready, 1);
        chk("busy_run", bus.busy, 1);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = r*8 + c;
                if (stop_after >= 0 && n >= stop_after) return;
                if (swap_m && n == 18) bus.m = 2'b11;
                bus.in_valid = 1'b1;
                bus.in_pix   = pixv(kind, r, c);
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                if (n != 63) begin
                    repeat (gaps) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    task automatic clear_logs();
        q13.delete();
        q10.delete();
        ans_cnt = 0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.m        = 2'b00;
        bus.in_valid = 1'b1;
        bus.in_pix   = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pix", bus.out_pix, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ans", bus.ans, 0);
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", bus.in_ready, 0);

        // Identity on the ramp; start raised during DONE must be ignored.
        clear_logs();
        send_frame(0, 2'b00, 0, -1, 1'b0);
        chk("done_ans", bus.ans, 1);
        chk("done_out_valid", bus.out_valid, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_last_pix", int'($signed(bus.out_pix)), 54);
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("after_done_ans", bus.ans, 0);
        chk("after_done_busy", bus.busy, 0);
        chk("after_done_in_ready", bus.in_ready, 0);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ident_count", q13.size(), 36);
        chk("ident_first", q13[0], 9);
        chk("ident_second", q13[1], 10);
        chk("ident_last", q13[35], 54);
        for (int k = 0; k < q13.size(); k++) chk("ident_val", q13[k], 8*(k/6 + 1) + (k%6) + 1);
        chk("ident_ans_cnt", ans_cnt, 1);
        chk("ident_out_pix_hold", int'($signed(bus.out_pix)), 54);
        $display("frame identity ramp outputs=%0d ans=%0d", q13.size(), ans_cnt);

        // Box sum of a saturated frame, both output widths.
        clear_logs();
        send_frame(1, 2'b01, 0, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("box_count", q13.size(), 36);
        chk("box_sat_count", q10.size(), 36);
        for (int k = 0; k < q13.size(); k++) chk("box_val", q13[k], 2295);
        for (int k = 0; k < q10.size(); k++) chk("box_sat_val", q10[k], 511);
        $display("frame box 255 outputs=%0d ow10_outputs=%0d", q13.size(), q10.size());

        // Sobel-x on the ramp: horizontal gradient of 1 per column gives 8 everywhere.
        clear_logs();
        send_frame(0, 2'b11, 0, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("sobel_count", q13.size(), 36);
        for (int k = 0; k < q13.size(); k++) chk("sobel_val", q13[k], 8);
        $display("frame sobel ramp outputs=%0d", q13.size());

        // Laplacian of a single 200 spike at (3,3); output index = (centre_r-1)*6 + (centre_c-1).
        clear_logs();
        send_frame(2, 2'b10, 0, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("lap_count", q13.size(), 36);
        chk("lap_centre_3_3", q13[14], 800);
        chk("lap_centre_2_3", q13[8], -200);
        chk("lap_centre_3_2", q13[13], -200);
        chk("lap_centre_2_2", q13[7], 0);
        chk("lap_centre_4_4", q13[21], 0);
        $display("frame laplacian spike outputs=%0d", q13.size());

        // Stalled identity run with m changed mid-frame.
        clear_logs();
        send_frame(0, 2'b00, 2, -1, 1'b1);
        chk("stall_done_ans", bus.ans, 1);
        bus.m = 2'b00;
        repeat (3) @(negedge clk);
        chk("stall_count", q13.size(), 36);
        for (int k = 0; k < q13.size(); k++) chk("stall_val", q13[k], 8*(k/6 + 1) + (k%6) + 1);
        chk("stall_ans_cnt", ans_cnt, 1);
        $display("frame stalled identity outputs=%0d ans=%0d", q13.size(), ans_cnt);

        // Reset after 20 pixels, then a fresh box frame of ones.
        clear_logs();
        send_frame(3, 2'b01, 0, 20, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_pix", bus.out_pix, 0);
        chk("midrst_ans", bus.ans, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_ans", ans_cnt, 0);
        clear_logs();
        send_frame(3, 2'b01, 0, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("ones_count", q13.size(), 36);
        for (int k = 0; k < q13.size(); k++) chk("ones_val", q13[k], 9);
        chk("ones_ans_cnt", ans_cnt, 1);
        $display("frame ones after reset outputs=%0d ans=%0d", q13.size(), ans_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3x3 convolution engine, the successor to the fixed four-output convolution block. It accepts one raster-order frame of IMG_W x IMG_H pixels through a valid/ready input port. Line buffers build each 3x3 window, and the engine emits one signed result per valid (unpadded) window using one of four built-in kernels selected by `m`. It sits between the pixel source and the result sink and raises `ans` when a frame is finished.

## Interface
- DW, 8: input pixel width (unsigned)
- IMG_W, 8: frame width in pixels (>=3)
- IMG_H, 8: frame height in pixels (>=3)
- OW, 13: output width (signed two's complement); results saturate to the OW range
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin frame; sampled in IDLE only
- m  in  2  kernel select; latched on accepted start
- in_valid  in  1  pixel present
- in_ready  out  1  engine accepts pixel
- in_pix  in  DW  pixel value
- out_valid  out  1  out_pix valid this cycle (no backpressure)
- out_pix  out  OW  convolution result
- busy  out  1  frame in progress (RUN or DONE)
- ans  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=0. start=1 moves to RUN, latches m into mode_q, and clears the row/col counters.
  - RUN: in_ready=1. A pixel is accepted when in_valid & in_ready.
  - DONE: lasts one cycle, then returns to IDLE.
- start is ignored in RUN and DONE. Changes to m after latching have no effect until the next start.
- Counters r (0..IMG_H-1) and c (0..IMG_W-1) track the position of the accepted pixel. c wraps to 0 and r increments at c=IMG_W-1.
- Two line buffers of IMG_W x DW hold the previous two rows. A 3x3 window shift register is fed from the line buffers plus in_pix.
- Window output condition: the accepted pixel is at (r,c) with r>=2 and c>=2. Window element w[i][j] = pixel(r-2+i, c-2+j), with i,j in 0..2.
- Result = sum of k[i][j]*w[i][j]. Kernels by mode_q:
  - 00 identity: k[1][1]=1, all others 0.
  - 01 box sum: all coefficients 1 (no division).
  - 10 Laplacian: centre 4; k[0][1], k[1][0], k[1][2], k[2][1] = -1; corners 0.
  - 11 Sobel-x: rows (-1,0,1), (-2,0,2), (-1,0,1).
- Arithmetic is performed at full internal width DW+5 signed. The result is clamped to [-2^(OW-1), 2^(OW-1)-1] before registering.
- Outputs per frame: (IMG_W-2)*(IMG_H-2).
- Accepting the last pixel (IMG_H-1, IMG_W-1) moves the engine to DONE.
- Line buffer contents are not reset. Only complete windows produce output, so stale data never reaches out_pix.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_pix=0, busy=0, ans=0, counters=0, mode_q=00.
- Latency: out_valid and out_pix are registered, asserted in the cycle after the window-completing pixel is accepted. out_pix holds its value when out_valid=0.
- in_valid gaps: no output, counters hold, no timeout.
- Frame end: the cycle after the last pixel is accepted has state=DONE, out_valid=1 (last result) and ans=1 together. The following cycle is IDLE with busy=0.
- start asserted in the same cycle as DONE is ignored. start must be seen in IDLE.
- rst mid-frame: immediately forces all reset values. A partial frame is discarded and no ans is produced.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and start=1 -> in_ready=0, out_valid=0, out_pix=0, busy=0, ans=0.
- Identity ramp: m=00, 8x8 frame with pixel=8r+c, in_valid held high -> 36 outputs. First output is 9, the next is 10, and the last is 54. ans=1 only with the 36th output, exactly one cycle after the last pixel is accepted.
- Box and saturation: m=01, constant 255 frame -> every output 2295. Rerun with OW=10 -> every output 511 (clamped).
- Sobel-x and Laplacian: m=11 on the ramp frame -> every output 8. m=10 on a frame of zeros with pixel(3,3)=200 -> window centred at (3,3) gives 800, windows centred at (2,3) and (3,2) give -200, and the window centred at (2,2) gives 0.
- Stalls and mode change: ramp frame with m=00, in_valid toggling 1,0,0,1..., and m switched to 11 mid-frame -> output values identical to the gap-free identity run. Exactly 36 out_valid pulses and one ans.
- Reset mid-frame: assert rst after 20 pixels, release, start a new frame with m=01 and constant 1 -> no ans from the first frame. The second frame gives 36 outputs equal to 9 and one ans.
